sha_state_reader: RTL and testbench

Read-back and digest-accumulation engine for the SHA-256 round datapath. After the 64 compression rounds of a message block have run, it walks the round block's working-variable memory (addresses 1–8 = A..H) through the `mem_out_addr` / `en_mem_out` / `out_var` read port. It adds each word into the running hash state H0..H7 (mod 2^32) and presents the 256-bit digest with a one-cycle `done` pulse. It is the consumer end of the same register-file port that the loader writes through `mem_in_addr` / `in_var`.

---
 rtl/sha_state_reader.sv | 130 +++++++++++++
 tb/tb_sha_state_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_state_reader.sv
// rtl/sha_state_reader.sv - reads working variables A..H and accumulates them into the SHA-256 hash state
module sha_state_reader #(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear_iv,
    output logic [3:0]   mem_out_addr,
    output logic         en_mem_out,
    input  logic [31:0]  out_var,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [2:0] DRAIN_LAST = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        cap_vld;
    logic [2:0]  cap_idx;
    logic [31:0] h [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts issued addresses in ISSUE and elapsed wait cycles in DRAIN
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        en_mem_out   = 1'b0;
        mem_out_addr = 4'd0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                en_mem_out   = 1'b1;
                mem_out_addr = {1'b0, cnt} + 4'd1;
                busy         = 1'b1;
                cnt_nxt      = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    cnt_nxt   = 3'd0;
                    state_nxt = (RD_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == DRAIN_LAST) begin
                    cnt_nxt   = 3'd0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue-side valid/index travel alongside the read so each word lands in its own H slot
    generate
        if (RD_LAT == 0) begin : g_comb
            assign cap_vld = en_mem_out;
            assign cap_idx = cnt;
        end else begin : g_pipe
            logic [RD_LAT-1:0] vld_q;
            logic [2:0]        idx_q [RD_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < RD_LAT; i++) idx_q[i] <= 3'd0;
                end else begin
                    vld_q[0] <= en_mem_out;
                    idx_q[0] <= cnt;
                    for (int i = 1; i < RD_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign cap_vld = vld_q[RD_LAT-1];
            assign cap_idx = idx_q[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) h[i] <= IV[255-32*i -: 32];
        end else if (state == IDLE && clear_iv) begin
            for (int i = 0; i < 8; i++) h[i] <= IV[255-32*i -: 32];
        end else if (cap_vld) begin
            h[cap_idx] <= h[cap_idx] + out_var;
        end
    end

    generate
        for (genvar g = 0; g < 8; g++) begin : g_digest
            assign digest[255-32*g -: 32] = h[g];
        end
    endgenerate

endmodule

// File: tb/tb_sha_state_reader.sv
// tb/tb_sha_state_reader.sv - scoreboard bench running RD_LAT = 0, 1, 2 instances side by side
module tb_sha_state_reader;

    localparam logic [31:0] JUNK = 32'hdeadbeef;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         clear_iv = 1'b0;
    logic [3:0]   addr [3];
    logic         en [3];
    logic [31:0]  ov [3];
    logic         busy [3];
    logic         done [3];
    logic [255:0] dig [3];

    logic [31:0]  mem [0:15];
    logic [31:0]  ivw [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0]  h_ref [8];
    logic [255:0] exp_dig [$];
    int           exp_c [$];
    int           rd_ptr [3];
    int           act_c = -100;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            sha_state_reader #(.RD_LAT(g)) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .start        (start),
                .clear_iv     (clear_iv),
                .mem_out_addr (addr[g]),
                .en_mem_out   (en[g]),
                .out_var      (ov[g]),
                .busy         (busy[g]),
                .done         (done[g]),
                .digest       (dig[g])
            );
            if (g == 0) begin : g_rd0
                assign ov[g] = en[g] ? mem[addr[g]] : JUNK;
            end else begin : g_rdn
                logic [31:0] d1, d2;
                always @(posedge clk) begin
                    d1 <= en[g] ? mem[addr[g]] : JUNK;
                    d2 <= d1;
                end
                assign ov[g] = (g == 1) ? d1 : d2;
            end
        end
    endgenerate

    task automatic chk(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut_lat%0d cycle %0d actual=%0h required=%0h", nm, d, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] pack_ref();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h_ref[i];
        return r;
    endfunction

    function automatic logic [255:0] pack_iv();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = ivw[i];
        return r;
    endfunction

    // Monitor: per-cycle port expectations plus scoreboard pop on every done
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                int rel;
                rel = cyc - act_c;
                chk("en_mem_out", d, 256'(en[d]), 256'(rel >= 1 && rel <= 8));
                chk("mem_out_addr", d, 256'(addr[d]), (rel >= 1 && rel <= 8) ? 256'(rel) : 256'd0);
                chk("busy", d, 256'(busy[d]), 256'(rel >= 1 && rel <= 8 + d));
                chk("done_timing", d, 256'(done[d]), 256'(rel == 9 + d));
                if (done[d]) begin
                    if (rd_ptr[d] >= exp_dig.size()) begin
                        chk("unexpected_done", d, 256'd1, 256'd0);
                    end else begin
                        chk("digest", d, dig[d], exp_dig[rd_ptr[d]]);
                        chk("done_cycle", d, 256'(cyc), 256'(exp_c[rd_ptr[d]] + 9 + d));
                        rd_ptr[d]++;
                    end
                end
            end
        end
    end

    task automatic issue(input bit with_clear);
        @(negedge clk);
        if (with_clear) for (int i = 0; i < 8; i++) h_ref[i] = ivw[i];
        for (int i = 0; i < 8; i++) h_ref[i] = h_ref[i] + mem[i+1];
        exp_dig.push_back(pack_ref());
        exp_c.push_back(cyc);
        act_c    = cyc;
        start    = 1'b1;
        clear_iv = with_clear;
        @(negedge clk);
        start    = 1'b0;
        clear_iv = 1'b0;
    endtask

    task automatic wait_done();
        int  n;
        bit  all;
        n = 0;
        all = 1'b0;
        while (n < 40 && !all) begin
            @(negedge clk);
            n++;
            all = (rd_ptr[0] == exp_dig.size()) && (rd_ptr[1] == exp_dig.size()) &&
                  (rd_ptr[2] == exp_dig.size());
        end
        checks++;
        if (!all) begin
            errors++;
            $display("FAIL done_timeout actual=no_done required=done within 40 cycles");
            for (int d = 0; d < 3; d++) rd_ptr[d] = exp_dig.size();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_iv = 1'b1;
        @(negedge clk);
        clear_iv = 1'b0;
        for (int i = 0; i < 8; i++) h_ref[i] = ivw[i];
        for (int d = 0; d < 3; d++) chk("clear_iv_digest", d, dig[d], pack_iv());
    endtask

    task automatic chk_reset_outputs(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_digest"}, d, dig[d], pack_iv());
            chk({nm, "_ports"}, d, {en[d], addr[d], busy[d], done[d]}, 256'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        for (int i = 0; i < 8; i++) h_ref[i] = ivw[i];
        for (int d = 0; d < 3; d++) rd_ptr[d] = 0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_reset");

        // zero data: digest stays at IV
        issue(1'b0);
        wait_done();

        // wrap-around with start and clear_iv together
        mem[1] = 32'h00000001;
        mem[5] = 32'haef1ad81;
        issue(1'b1);
        wait_done();

        // chaining two blocks, then IV reload
        do_clear();
        for (int i = 1; i <= 8; i++) mem[i] = 32'h00000001;
        issue(1'b0);
        wait_done();
        issue(1'b0);
        wait_done();
        do_clear();

        // start/clear_iv during ISSUE are ignored
        for (int i = 1; i <= 8; i++) mem[i] = $urandom;
        issue(1'b0);
        @(negedge clk);
        start    = 1'b1;
        clear_iv = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        clear_iv = 1'b0;
        wait_done();

        for (int r = 0; r < 8; r++) begin
            for (int i = 1; i <= 8; i++) mem[i] = $urandom;
            issue(1'($urandom_range(0, 1)));
            wait_done();
        end

        // reset in the middle of ISSUE abandons the block
        for (int i = 1; i <= 8; i++) mem[i] = $urandom;
        issue(1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) h_ref[i] = ivw[i];
        act_c = -100;
        for (int d = 0; d < 3; d++) rd_ptr[d] = exp_dig.size();
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_midrun_reset");

        issue(1'b0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
